// File: rtl/mem_pkg.sv
// Shared types, default widths and helpers for the two-requester memory arbiter.
// Imported by the interface, the arbiter top and its grant sub-module.
package mem_pkg;

    localparam int unsigned DefDataWidth = 32;
    localparam int unsigned DefAddrWidth = 5;
    localparam int unsigned DefRdTimeout = 15;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        RD_WAIT = 2'd2
    } state_t;

    function automatic logic [1:0] idx_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-side signals of the arbiter, bundled with directional views.
// slave = arbiter view, master = the environment driving requesters and memory.
interface mem_arbiter_if
    import mem_pkg::*;
#(
    parameter int unsigned Data_Width = DefDataWidth,
    parameter int unsigned Addr_Width = DefAddrWidth
) ();

    logic [1:0]              Req_Valid;
    logic [1:0]              Req_Ready;
    logic [1:0]              Req_Wr;
    logic [2*Addr_Width-1:0] Req_Addr;
    logic [2*Data_Width-1:0] Req_Data;

    logic [1:0]              Rsp_Valid;
    logic [1:0]              Rsp_Err;
    logic [Data_Width-1:0]   Rsp_Data;

    logic                    Mem_Wr_En;
    logic                    Mem_Rd_En;
    logic [Addr_Width-1:0]   Mem_Address;
    logic [Data_Width-1:0]   Mem_Data_in;
    logic [Data_Width-1:0]   Mem_Data_out;
    logic                    Mem_Valid_out;

    modport slave (
        input  Req_Valid, Req_Wr, Req_Addr, Req_Data, Mem_Data_out, Mem_Valid_out,
        output Req_Ready, Rsp_Valid, Rsp_Err, Rsp_Data,
        output Mem_Wr_En, Mem_Rd_En, Mem_Address, Mem_Data_in
    );

    modport master (
        output Req_Valid, Req_Wr, Req_Addr, Req_Data, Mem_Data_out, Mem_Valid_out,
        input  Req_Ready, Rsp_Valid, Rsp_Err, Rsp_Data,
        input  Mem_Wr_En, Mem_Rd_En, Mem_Address, Mem_Data_in
    );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: a lone request wins outright; on conflict the
// requester that was not granted last wins. Output is one-hot or zero.
module rr_arbiter2 (
    input  logic [1:0] request,
    input  logic       last,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        unique case (request)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port memory with a
// bounded read wait; exactly one command is in flight at a time.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int unsigned Data_Width = DefDataWidth,
    parameter int unsigned Addr_Width = DefAddrWidth,
    parameter int unsigned Rd_Timeout = DefRdTimeout
) (
    input logic          CLK,
    input logic          Rst,
    mem_arbiter_if.slave bus
);

    localparam int unsigned CntWidth = $clog2(Rd_Timeout + 1);

    state_t                state_q;
    logic                  last_q;
    logic                  gnt_idx_q;
    logic                  wr_q;
    logic [Addr_Width-1:0] addr_q;
    logic [Data_Width-1:0] data_q;
    logic                  mem_wr_en_q;
    logic                  mem_rd_en_q;
    logic [1:0]            rsp_valid_q;
    logic [1:0]            rsp_err_q;
    logic [Data_Width-1:0] rsp_data_q;
    logic [CntWidth-1:0]   cnt_q;

    logic [1:0]            grant;
    logic [1:0]            req_ready;
    logic                  handshake;
    logic                  sel_idx;
    logic                  sel_wr;
    logic [Addr_Width-1:0] sel_addr;
    logic [Data_Width-1:0] sel_data;

    rr_arbiter2 u_rr (
        .request (bus.Req_Valid),
        .last    (last_q),
        .grant   (grant)
    );

    // Ready is combinational from the grant, but held low while reset is asserted.
    always_comb begin
        req_ready = (state_q == IDLE && !Rst) ? grant : 2'b00;
        handshake = |(bus.Req_Valid & req_ready);
        sel_idx   = req_ready[1];
        sel_wr    = bus.Req_Wr[sel_idx];
        sel_addr  = sel_idx ? bus.Req_Addr[2*Addr_Width-1:Addr_Width]
                            : bus.Req_Addr[Addr_Width-1:0];
        sel_data  = sel_idx ? bus.Req_Data[2*Data_Width-1:Data_Width]
                            : bus.Req_Data[Data_Width-1:0];
    end

    always_ff @(posedge CLK or posedge Rst) begin
        if (Rst) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            gnt_idx_q   <= 1'b0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            mem_wr_en_q <= 1'b0;
            mem_rd_en_q <= 1'b0;
            rsp_valid_q <= 2'b00;
            rsp_err_q   <= 2'b00;
            rsp_data_q  <= '0;
            cnt_q       <= '0;
        end else begin
            rsp_valid_q <= 2'b00;
            rsp_err_q   <= 2'b00;
            unique case (state_q)
                IDLE: begin
                    if (handshake) begin
                        wr_q        <= sel_wr;
                        addr_q      <= sel_addr;
                        data_q      <= sel_data;
                        gnt_idx_q   <= sel_idx;
                        last_q      <= sel_idx;
                        mem_wr_en_q <= sel_wr;
                        mem_rd_en_q <= !sel_wr;
                        state_q     <= ISSUE;
                    end
                end
                ISSUE: begin
                    mem_wr_en_q <= 1'b0;
                    mem_rd_en_q <= 1'b0;
                    cnt_q       <= '0;
                    state_q     <= wr_q ? IDLE : RD_WAIT;
                end
                RD_WAIT: begin
                    // A return on the final counted cycle still beats the timeout.
                    if (bus.Mem_Valid_out) begin
                        rsp_data_q  <= bus.Mem_Data_out;
                        rsp_valid_q <= idx_onehot(gnt_idx_q);
                        state_q     <= IDLE;
                    end else if (cnt_q == CntWidth'(Rd_Timeout)) begin
                        rsp_data_q  <= '0;
                        rsp_valid_q <= idx_onehot(gnt_idx_q);
                        rsp_err_q   <= idx_onehot(gnt_idx_q);
                        state_q     <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + CntWidth'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.Req_Ready   = req_ready;
    assign bus.Rsp_Valid   = rsp_valid_q;
    assign bus.Rsp_Err     = rsp_err_q;
    assign bus.Rsp_Data    = rsp_data_q;
    assign bus.Mem_Wr_En   = mem_wr_en_q;
    assign bus.Mem_Rd_En   = mem_rd_en_q;
    assign bus.Mem_Address = addr_q;
    assign bus.Mem_Data_in = data_q;

    a_strobe_excl: assert property (@(posedge CLK) disable iff (Rst)
        !(mem_wr_en_q && mem_rd_en_q));
    a_ready_onehot: assert property (@(posedge CLK) disable iff (Rst)
        $onehot0(req_ready));
    a_strobe_issue: assert property (@(posedge CLK) disable iff (Rst)
        (mem_wr_en_q || mem_rd_en_q) |-> state_q == ISSUE);
    a_rsp_onehot: assert property (@(posedge CLK) disable iff (Rst)
        $onehot0(rsp_valid_q));

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: reset values, a vector table of write grants, directed
// read/timeout/stray/reset sequences and a randomized run against a timing model.
module tb_mem_arbiter;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;
    localparam int          TO = 15;
    localparam int          NVEC = 7;

    logic CLK = 1'b0;
    logic Rst;
    always #5 CLK = ~CLK;

    mem_arbiter_if #(.Data_Width(DW), .Addr_Width(AW)) bus ();

    mem_arbiter #(.Data_Width(DW), .Addr_Width(AW), .Rd_Timeout(TO)) dut (
        .CLK (CLK),
        .Rst (Rst),
        .bus (bus)
    );

    typedef struct {
        logic [1:0]    valid;
        logic [1:0]    wr;
        logic [AW-1:0] a0, a1;
        logic [DW-1:0] d0, d1;
        logic [1:0]    exp_ready;
        logic          exp_wr, exp_rd;
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] exp_data;
    } vec_t;

    int checks = 0;
    int errors = 0;

    vec_t          vecs [NVEC];
    logic [1:0]    pend;
    logic          q_wr [2];
    logic [AW-1:0] q_addr [2];
    logic [DW-1:0] q_data [2];
    logic [DW-1:0] mem_m [32];
    int            free_at, issue_at, rsp_at, mv_at, lat;
    logic          m_last, cur_g, cur_wr, rsp_err_m, stray;
    logic [AW-1:0] cur_addr;
    logic [DW-1:0] cur_data, mv_data, rsp_data_m;
    logic [1:0]    exp_ready, exp_onehot;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic next();
        @(posedge CLK);
        #1;
    endtask

    task automatic sample();
        @(negedge CLK);
    endtask

    task automatic drive_req(input logic [1:0] v, input logic [1:0] w,
                             input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                             input logic [DW-1:0] d0, input logic [DW-1:0] d1);
        bus.Req_Valid = v;
        bus.Req_Wr    = w;
        bus.Req_Addr  = {a1, a0};
        bus.Req_Data  = {d1, d0};
    endtask

    task automatic do_reset();
        drive_req(2'b00, 2'b00, '0, '0, '0, '0);
        bus.Mem_Valid_out = 1'b0;
        Rst = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        Rst = 1'b0;
    endtask

    function automatic vec_t mk(input logic [1:0] v, input logic [1:0] w,
                                input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                                input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                                input logic [1:0] er, input logic ew, input logic erd,
                                input logic [AW-1:0] ea, input logic [DW-1:0] ed);
        vec_t r;
        r.valid = v;  r.wr = w;  r.a0 = a0;  r.a1 = a1;  r.d0 = d0;  r.d1 = d1;
        r.exp_ready = er;  r.exp_wr = ew;  r.exp_rd = erd;
        r.exp_addr = ea;  r.exp_data = ed;
        return r;
    endfunction

    // Round-robin rule: lone requester wins; on conflict the one not granted last.
    function automatic logic [1:0] rr_pick(input logic [1:0] v, input logic last);
        if (v == 2'b11) return last ? 2'b01 : 2'b10;
        return v;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vecs[0] = mk(2'b01, 2'b11, 5'd3, 5'd2, 32'hDEADBEEF, 32'h22222222,
                     2'b01, 1'b1, 1'b0, 5'd3, 32'hDEADBEEF);
        vecs[1] = mk(2'b11, 2'b11, 5'd1, 5'd2, 32'h11111111, 32'h22222222,
                     2'b10, 1'b1, 1'b0, 5'd2, 32'h22222222);
        vecs[2] = mk(2'b11, 2'b11, 5'd1, 5'd2, 32'h11111111, 32'h22222222,
                     2'b01, 1'b1, 1'b0, 5'd1, 32'h11111111);
        vecs[3] = mk(2'b11, 2'b11, 5'd1, 5'd2, 32'h11111111, 32'h22222222,
                     2'b10, 1'b1, 1'b0, 5'd2, 32'h22222222);
        vecs[4] = mk(2'b00, 2'b11, 5'd1, 5'd2, 32'h11111111, 32'h22222222,
                     2'b00, 1'b0, 1'b0, 5'd0, 32'h0);
        vecs[5] = mk(2'b10, 2'b11, 5'd1, 5'd2, 32'h11111111, 32'h22222222,
                     2'b10, 1'b1, 1'b0, 5'd2, 32'h22222222);
        vecs[6] = mk(2'b11, 2'b11, 5'd1, 5'd2, 32'h11111111, 32'h22222222,
                     2'b01, 1'b1, 1'b0, 5'd1, 32'h11111111);

        // Reset values, with both requesters asking during reset.
        Rst = 1'b1;
        drive_req(2'b11, 2'b11, 5'd9, 5'd10, 32'h1, 32'h2);
        bus.Mem_Valid_out = 1'b0;
        bus.Mem_Data_out  = '0;
        sample();
        chk("rst_ready", 64'(bus.Req_Ready), 64'(2'b00));
        chk("rst_wr_en", 64'(bus.Mem_Wr_En), 64'(1'b0));
        chk("rst_rd_en", 64'(bus.Mem_Rd_En), 64'(1'b0));
        chk("rst_rsp_valid", 64'(bus.Rsp_Valid), 64'(2'b00));
        chk("rst_rsp_err", 64'(bus.Rsp_Err), 64'(2'b00));
        chk("rst_rsp_data", 64'(bus.Rsp_Data), 64'(0));
        chk("rst_addr", 64'(bus.Mem_Address), 64'(0));
        chk("rst_data_in", 64'(bus.Mem_Data_in), 64'(0));
        next();
        Rst = 1'b0;
        drive_req(2'b00, 2'b00, '0, '0, '0, '0);

        // Table: one write grant per two cycles, requests held through the issue cycle.
        for (int r = 0; r < NVEC; r++) begin
            drive_req(vecs[r].valid, vecs[r].wr, vecs[r].a0, vecs[r].a1, vecs[r].d0, vecs[r].d1);
            sample();
            chk("tbl_ready", 64'(bus.Req_Ready), 64'(vecs[r].exp_ready));
            chk("tbl_idle_wr_en", 64'(bus.Mem_Wr_En), 64'(1'b0));
            next();
            sample();
            chk("tbl_busy_ready", 64'(bus.Req_Ready), 64'(2'b00));
            chk("tbl_wr_en", 64'(bus.Mem_Wr_En), 64'(vecs[r].exp_wr));
            chk("tbl_rd_en", 64'(bus.Mem_Rd_En), 64'(vecs[r].exp_rd));
            if (vecs[r].exp_wr || vecs[r].exp_rd) begin
                chk("tbl_addr", 64'(bus.Mem_Address), 64'(vecs[r].exp_addr));
                chk("tbl_data", 64'(bus.Mem_Data_in), 64'(vecs[r].exp_data));
            end
            next();
        end
        drive_req(2'b00, 2'b00, '0, '0, '0, '0);

        // Requester 1 read of address 7, memory answers two cycles after the strobe.
        drive_req(2'b10, 2'b00, 5'd0, 5'd7, 32'h0, 32'h0);
        sample();
        chk("rd1_ready", 64'(bus.Req_Ready), 64'(2'b10));
        next();
        drive_req(2'b00, 2'b00, 5'd0, 5'd7, 32'h0, 32'h0);
        sample();
        chk("rd1_rd_en", 64'(bus.Mem_Rd_En), 64'(1'b1));
        chk("rd1_wr_en", 64'(bus.Mem_Wr_En), 64'(1'b0));
        chk("rd1_addr", 64'(bus.Mem_Address), 64'(5'd7));
        next();
        sample();
        chk("rd1_rd_en_off", 64'(bus.Mem_Rd_En), 64'(1'b0));
        next();
        bus.Mem_Valid_out = 1'b1;
        bus.Mem_Data_out  = 32'h12345678;
        sample();
        chk("rd1_early_rsp", 64'(bus.Rsp_Valid), 64'(2'b00));
        next();
        bus.Mem_Valid_out = 1'b0;
        bus.Mem_Data_out  = '0;
        sample();
        chk("rd1_rsp_valid", 64'(bus.Rsp_Valid), 64'(2'b10));
        chk("rd1_rsp_err", 64'(bus.Rsp_Err), 64'(2'b00));
        chk("rd1_rsp_data", 64'(bus.Rsp_Data), 64'(32'h12345678));
        next();

        // Requester 0 read with no memory return: timeout pulse, then next command taken.
        drive_req(2'b01, 2'b00, 5'd9, 5'd0, 32'h0, 32'h0);
        sample();
        chk("to_ready", 64'(bus.Req_Ready), 64'(2'b01));
        next();
        drive_req(2'b00, 2'b00, '0, '0, '0, '0);
        sample();
        chk("to_rd_en", 64'(bus.Mem_Rd_En), 64'(1'b1));
        next();
        for (int k = 0; k <= TO; k++) begin
            sample();
            chk("to_wait_rsp", 64'(bus.Rsp_Valid), 64'(2'b00));
            next();
        end
        drive_req(2'b10, 2'b10, 5'd0, 5'd4, 32'h0, 32'h44444444);
        sample();
        chk("to_rsp_valid", 64'(bus.Rsp_Valid), 64'(2'b01));
        chk("to_rsp_err", 64'(bus.Rsp_Err), 64'(2'b01));
        chk("to_rsp_data", 64'(bus.Rsp_Data), 64'(0));
        chk("to_next_ready", 64'(bus.Req_Ready), 64'(2'b10));
        next();
        drive_req(2'b00, 2'b00, '0, '0, '0, '0);
        sample();
        chk("to_next_wr_en", 64'(bus.Mem_Wr_En), 64'(1'b1));
        chk("to_next_addr", 64'(bus.Mem_Address), 64'(5'd4));
        chk("to_next_data", 64'(bus.Mem_Data_in), 64'(32'h44444444));
        next();

        // Stray memory return while idle produces nothing.
        bus.Mem_Valid_out = 1'b1;
        bus.Mem_Data_out  = 32'hAAAA5555;
        sample();
        next();
        bus.Mem_Valid_out = 1'b0;
        sample();
        chk("stray_rsp_valid", 64'(bus.Rsp_Valid), 64'(2'b00));
        chk("stray_rsp_err", 64'(bus.Rsp_Err), 64'(2'b00));
        next();

        // Reset during a read wait: outputs clear at once, late return is ignored.
        drive_req(2'b01, 2'b00, 5'd5, 5'd0, 32'h0BADF00D, 32'h0);
        sample();
        chk("rr_ready", 64'(bus.Req_Ready), 64'(2'b01));
        next();
        drive_req(2'b00, 2'b00, '0, '0, '0, '0);
        sample();
        chk("rr_rd_en", 64'(bus.Mem_Rd_En), 64'(1'b1));
        next();
        #2;
        Rst = 1'b1;
        #1;
        chk("rr_async_rd_en", 64'(bus.Mem_Rd_En), 64'(1'b0));
        chk("rr_async_addr", 64'(bus.Mem_Address), 64'(0));
        chk("rr_async_data_in", 64'(bus.Mem_Data_in), 64'(0));
        chk("rr_async_rsp_valid", 64'(bus.Rsp_Valid), 64'(2'b00));
        @(posedge CLK);
        #1;
        Rst = 1'b0;
        bus.Mem_Valid_out = 1'b1;
        bus.Mem_Data_out  = 32'h55555555;
        sample();
        next();
        bus.Mem_Valid_out = 1'b0;
        for (int k = 0; k < 3; k++) begin
            sample();
            chk("rr_no_rsp", 64'(bus.Rsp_Valid), 64'(2'b00));
            next();
        end
        drive_req(2'b11, 2'b11, 5'd1, 5'd2, 32'h1, 32'h2);
        sample();
        chk("rr_first_grant", 64'(bus.Req_Ready), 64'(2'b01));
        next();
        drive_req(2'b00, 2'b00, '0, '0, '0, '0);
        next();

        // Randomized run against a transaction-timing model.
        do_reset();
        for (int i = 0; i < 32; i++) mem_m[i] = DW'($urandom);
        m_last = 1'b1;  free_at = 0;  issue_at = -1;  rsp_at = -1;  mv_at = -1;
        pend = 2'b00;  cur_wr = 1'b0;  cur_g = 1'b0;  rsp_err_m = 1'b0;
        rsp_data_m = '0;  mv_data = '0;  cur_addr = '0;  cur_data = '0;
        for (int i = 0; i < 2; i++) begin
            q_wr[i] = 1'b0;  q_addr[i] = '0;  q_data[i] = '0;
        end
        for (int t = 0; t < 3000; t++) begin
            for (int i = 0; i < 2; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i]   = 1'b1;
                    q_wr[i]   = 1'($urandom_range(0, 1));
                    q_addr[i] = AW'($urandom_range(0, 31));
                    q_data[i] = DW'($urandom);
                end else if (pend[i] && $urandom_range(0, 19) == 0) begin
                    pend[i] = 1'b0;
                end
            end
            drive_req(pend, {q_wr[1], q_wr[0]}, q_addr[0], q_addr[1], q_data[0], q_data[1]);
            stray = (t >= free_at || cur_wr) && ($urandom_range(0, 7) == 0);
            bus.Mem_Valid_out = (t == mv_at) || stray;
            bus.Mem_Data_out  = (t == mv_at) ? mv_data : DW'($urandom);
            sample();
            exp_ready  = (t >= free_at) ? rr_pick(pend, m_last) : 2'b00;
            exp_onehot = cur_g ? 2'b10 : 2'b01;
            chk("rnd_ready", 64'(bus.Req_Ready), 64'(exp_ready));
            chk("rnd_wr_en", 64'(bus.Mem_Wr_En), 64'(t == issue_at && cur_wr));
            chk("rnd_rd_en", 64'(bus.Mem_Rd_En), 64'(t == issue_at && !cur_wr));
            if (t == issue_at) begin
                chk("rnd_addr", 64'(bus.Mem_Address), 64'(cur_addr));
                if (cur_wr) chk("rnd_data_in", 64'(bus.Mem_Data_in), 64'(cur_data));
            end
            chk("rnd_rsp_valid", 64'(bus.Rsp_Valid), 64'((t == rsp_at) ? exp_onehot : 2'b00));
            chk("rnd_rsp_err", 64'(bus.Rsp_Err),
                64'((t == rsp_at && rsp_err_m) ? exp_onehot : 2'b00));
            if (t == rsp_at) chk("rnd_rsp_data", 64'(bus.Rsp_Data), 64'(rsp_data_m));
            if (exp_ready != 2'b00) begin
                cur_g    = exp_ready[1];
                m_last   = cur_g;
                issue_at = t + 1;
                cur_wr   = q_wr[cur_g];
                cur_addr = q_addr[cur_g];
                cur_data = q_data[cur_g];
                pend[cur_g] = 1'b0;
                if (cur_wr) begin
                    mem_m[cur_addr] = cur_data;
                    free_at = t + 2;
                end else begin
                    lat = ($urandom_range(0, 3) == 0) ? int'($urandom_range(15, 18))
                                                      : int'($urandom_range(1, 6));
                    if (lat <= TO + 1) begin
                        mv_at      = t + 1 + lat;
                        mv_data    = mem_m[cur_addr];
                        rsp_at     = mv_at + 1;
                        rsp_err_m  = 1'b0;
                        rsp_data_m = mv_data;
                    end else begin
                        mv_at      = -1;
                        rsp_at     = t + 3 + TO;
                        rsp_err_m  = 1'b1;
                        rsp_data_m = '0;
                    end
                    free_at = rsp_at;
                end
            end
            next();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
